// File: rtl/pc_addr_unit_pkg.sv
// Shared definitions for the program-counter / address unit:
// sequencer state encoding, memory command codes and PC update modes.
package pc_addr_unit_pkg;

    // Sequencer states: one idle state plus one state per access kind.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DATA_RD = 2'b10,
        ST_DATA_WR = 2'b11
    } state_t;

    // Memory command codes driven on mem_cmd.
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    // PC update modes selected by pc_mode when load_pc is accepted.
    localparam logic [1:0] PCM_INC = 2'b00;   // pc + 1
    localparam logic [1:0] PCM_REL = 2'b01;   // pc + 1 + sign-extended offset
    localparam logic [1:0] PCM_ABS = 2'b10;   // absolute target
    localparam logic [1:0] PCM_RST = 2'b11;   // back to the reset vector

    // Memory command implied by a sequencer state.
    function automatic logic [1:0] cmd_for_state(input state_t s);
        logic [1:0] cmd;
        cmd = CMD_NONE;
        case (s)
            ST_FETCH:   cmd = CMD_READ;
            ST_DATA_RD: cmd = CMD_READ;
            ST_DATA_WR: cmd = CMD_WRITE;
            default:    cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC calculator. All arithmetic wraps modulo 2^ADDR_W;
// the branch offset is sign-extended (or truncated) to ADDR_W bits first.
module pc_next
    import pc_addr_unit_pkg::*;
#(
    parameter int              ADDR_W    = 9,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_mode,
    input  logic [DATA_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_nxt
);

    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] pc_inc;

    // Offset bits above ADDR_W do not affect a modulo-2^ADDR_W sum; fold
    // them into one bit so the whole operand is visibly consumed.
    logic offset_unused;
    assign offset_unused = ^offset;

    // Build the ADDR_W-bit displacement bit by bit: copy low bits, replicate
    // the sign bit where the operand is narrower than the address.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_sext
            if (gi < DATA_W) begin : g_bit
                assign offset_ext[gi] = offset[gi];
            end else begin : g_sign
                assign offset_ext[gi] = offset[DATA_W-1];
            end
        end
    endgenerate

    assign pc_inc = pc + ADDR_W'(1);

    // Select the next PC according to the requested update mode.
    always_comb begin
        pc_nxt = pc_inc;
        case (pc_mode)
            PCM_INC: pc_nxt = pc_inc;
            PCM_REL: pc_nxt = pc_inc + offset_ext;
            PCM_ABS: pc_nxt = target;
            PCM_RST: pc_nxt = RESET_VEC;
            default: pc_nxt = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_addr_unit.sv
// Program-counter and memory-address unit. Holds the PC and a data address
// register, and sequences single instruction-fetch or data accesses to a
// memory that signals completion with mem_ready.
module pc_addr_unit
    import pc_addr_unit_pkg::*;
#(
    parameter int                ADDR_W    = 9,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              load_pc,
    input  logic [1:0]        pc_mode,
    input  logic [DATA_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic              busy,
    output logic              done,
    output logic              done_fetch,
    output logic [ADDR_W-1:0] pc
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] daddr_reg;
    logic [ADDR_W-1:0] pc_calc;
    logic              done_reg;
    logic              done_fetch_reg;

    logic              in_data;
    logic              access_end;
    logic              pc_en;
    logic              addr_en;

    assign in_data    = (state_reg == ST_DATA_RD) || (state_reg == ST_DATA_WR);
    // An access finishes when memory reports ready in any busy state;
    // mem_ready seen while idle is deliberately ignored.
    assign access_end = (state_reg != ST_IDLE) && mem_ready;
    // PC is frozen while its value is on the bus for a fetch.
    assign pc_en      = load_pc && (state_reg != ST_FETCH);
    // Data address is frozen while it is on the bus for a data access.
    assign addr_en    = load_addr && !in_data;

    pc_next #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_VEC (RESET_VEC)
    ) u_pc_next (
        .pc      (pc_reg),
        .pc_mode (pc_mode),
        .offset  (offset),
        .target  (target),
        .pc_nxt  (pc_calc)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start one access from idle (fetch has priority),
    // hold it until mem_ready; requests during an access are dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_next = ST_FETCH;
                end else if (data_req) begin
                    state_next = data_we ? ST_DATA_WR : ST_DATA_RD;
                end
            end
            ST_FETCH, ST_DATA_RD, ST_DATA_WR: begin
                if (mem_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Program counter: load-enabled register fed by the next-PC calculator.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_VEC;
        end else if (pc_en) begin
            pc_reg <= pc_calc;
        end
    end

    // Data address register: load-enabled from the datapath result.
    always_ff @(posedge clk) begin
        if (reset) begin
            daddr_reg <= '0;
        end else if (addr_en) begin
            daddr_reg <= addr_in;
        end
    end

    // Completion pulse, one cycle after the access ends, tagged with its kind.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_reg       <= 1'b0;
            done_fetch_reg <= 1'b0;
        end else begin
            done_reg       <= access_end;
            done_fetch_reg <= access_end && (state_reg == ST_FETCH);
        end
    end

    // Bus outputs decoded directly from the current state.
    always_comb begin
        mem_cmd  = cmd_for_state(state_reg);
        mem_addr = in_data ? daddr_reg : pc_reg;
        busy     = (state_reg != ST_IDLE);
    end

    assign done       = done_reg;
    assign done_fetch = done_fetch_reg;
    assign pc         = pc_reg;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Self-checking bench for pc_addr_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the unit.
module tb_pc_addr_unit;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int RESET_VEC = 0;
    localparam int MASK      = (1 << ADDR_W) - 1;

    logic              clk;
    logic              reset;
    logic              fetch_req;
    logic              data_req;
    logic              data_we;
    logic              load_addr;
    logic [ADDR_W-1:0] addr_in;
    logic              load_pc;
    logic [1:0]        pc_mode;
    logic [DATA_W-1:0] offset;
    logic [ADDR_W-1:0] target;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_cmd;
    logic              busy;
    logic              done;
    logic              done_fetch;
    logic [ADDR_W-1:0] pc;

    int tests = 0;
    int fails = 0;

    pc_addr_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_VEC (9'(RESET_VEC))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .data_req   (data_req),
        .data_we    (data_we),
        .load_addr  (load_addr),
        .addr_in    (addr_in),
        .load_pc    (load_pc),
        .pc_mode    (pc_mode),
        .offset     (offset),
        .target     (target),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_cmd    (mem_cmd),
        .busy       (busy),
        .done       (done),
        .done_fetch (done_fetch),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // access: 0 none, 1 instruction fetch, 2 data read, 3 data write
    int m_access;
    int m_pc;
    int m_daddr;
    bit m_done;
    bit m_done_fetch;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int n_access;
        int n_pc;
        int n_daddr;
        bit n_done;
        bit n_df;
        if (reset) begin
            m_access     = 0;
            m_pc         = RESET_VEC;
            m_daddr      = 0;
            m_done       = 1'b0;
            m_done_fetch = 1'b0;
            m_valid      = 1'b1;
        end else if (m_valid) begin
            n_pc    = m_pc;
            n_daddr = m_daddr;
            n_done  = (m_access != 0) && mem_ready;
            n_df    = (m_access == 1) && mem_ready;
            if (load_pc && m_access != 1) begin
                case (pc_mode)
                    2'd0: n_pc = (m_pc + 1) & MASK;
                    2'd1: n_pc = (m_pc + 1 + int'($signed(offset))) & MASK;
                    2'd2: n_pc = int'(target);
                    default: n_pc = RESET_VEC;
                endcase
            end
            if (load_addr && m_access < 2) n_daddr = int'(addr_in);
            if (m_access == 0) begin
                if (fetch_req)     n_access = 1;
                else if (data_req) n_access = data_we ? 3 : 2;
                else               n_access = 0;
            end else begin
                n_access = mem_ready ? 0 : m_access;
            end
            m_access     = n_access;
            m_pc         = n_pc;
            m_daddr      = n_daddr;
            m_done       = n_done;
            m_done_fetch = n_df;
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        int e_cmd;
        int e_addr;
        if (m_valid) begin
            e_cmd  = (m_access == 1 || m_access == 2) ? 1 : (m_access == 3 ? 2 : 0);
            e_addr = (m_access >= 2) ? m_daddr : m_pc;
            check("model_mem_cmd", 32'(mem_cmd), 32'(e_cmd));
            check("model_mem_addr", 32'(mem_addr), 32'(e_addr));
            check("model_busy", 32'(busy), 32'(m_access != 0));
            check("model_done", 32'(done), 32'(m_done));
            check("model_done_fetch", 32'(done_fetch), 32'(m_done_fetch));
            check("model_pc", 32'(pc), 32'(m_pc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset     = 1'b0;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        load_addr = 1'b0;
        addr_in   = '0;
        load_pc   = 1'b0;
        pc_mode   = 2'b00;
        offset    = '0;
        target    = '0;
        mem_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_pc", 32'(pc), 32'h000);
        check("reset_cmd", 32'(mem_cmd), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Fetch with two wait cycles.
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fetch_cmd", 32'(mem_cmd), 32'h1);
            check("fetch_addr", 32'(mem_addr), 32'h000);
            check("fetch_no_done", 32'(done), 32'h0);
            mem_ready = (i == 2);
            step();
        end
        mem_ready = 1'b0;
        check("fetch_done", 32'(done), 32'h1);
        check("fetch_done_fetch", 32'(done_fetch), 32'h1);
        check("fetch_idle_cmd", 32'(mem_cmd), 32'h0);
        step();
        check("fetch_done_pulse", 32'(done), 32'h0);

        // Data write with immediate ready.
        load_addr = 1'b1;
        addr_in   = 9'h1A5;
        step();
        load_addr = 1'b0;
        data_req  = 1'b1;
        data_we   = 1'b1;
        step();
        data_req  = 1'b0;
        data_we   = 1'b0;
        check("wr_cmd", 32'(mem_cmd), 32'h2);
        check("wr_addr", 32'(mem_addr), 32'h1A5);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("wr_done", 32'(done), 32'h1);
        check("wr_done_fetch", 32'(done_fetch), 32'h0);

        // PC wrap and negative relative branch.
        load_pc = 1'b1;
        pc_mode = 2'b10;
        target  = 9'h1FF;
        step();
        check("pc_abs_1ff", 32'(pc), 32'h1FF);
        pc_mode = 2'b00;
        step();
        check("pc_wrap", 32'(pc), 32'h000);
        pc_mode = 2'b10;
        target  = 9'h005;
        step();
        pc_mode = 2'b01;
        offset  = 16'hFFFD;
        step();
        load_pc = 1'b0;
        check("pc_rel_neg", 32'(pc), 32'h003);

        // load_pc ignored during fetch, accepted in idle.
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        load_pc   = 1'b1;
        pc_mode   = 2'b10;
        target    = 9'h0C0;
        step();
        load_pc   = 1'b0;
        check("pc_frozen_fetch", 32'(pc), 32'h003);
        check("pc_frozen_busy", 32'(busy), 32'h1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        load_pc   = 1'b1;
        step();
        load_pc   = 1'b0;
        check("pc_abs_idle", 32'(pc), 32'h0C0);

        // Simultaneous requests: fetch wins; data request while busy dropped.
        fetch_req = 1'b1;
        data_req  = 1'b1;
        step();
        fetch_req = 1'b0;
        check("prio_cmd", 32'(mem_cmd), 32'h1);
        check("prio_addr", 32'(mem_addr), 32'h0C0);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        data_req  = 1'b0;
        check("prio_done_fetch", 32'(done_fetch), 32'h1);
        step();
        check("prio_no_data_cmd", 32'(mem_cmd), 32'h0);
        check("prio_no_data_busy", 32'(busy), 32'h0);

        // Reset aborts a data read.
        load_addr = 1'b1;
        addr_in   = 9'h033;
        step();
        load_addr = 1'b0;
        data_req  = 1'b1;
        step();
        data_req  = 1'b0;
        check("rd_cmd", 32'(mem_cmd), 32'h1);
        check("rd_addr", 32'(mem_addr), 32'h033);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_cmd", 32'(mem_cmd), 32'h0);
        check("abort_pc", 32'(pc), 32'(RESET_VEC));
        check("abort_done", 32'(done), 32'h0);
        step();
        check("abort_done_late", 32'(done), 32'h0);

        // Randomized traffic, checked by the compare process.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            fetch_req = ($urandom_range(0, 3) == 0);
            data_req  = ($urandom_range(0, 2) == 0);
            data_we   = 1'($urandom_range(0, 1));
            load_addr = ($urandom_range(0, 3) == 0);
            addr_in   = 9'($urandom);
            load_pc   = ($urandom_range(0, 2) == 0);
            pc_mode   = 2'($urandom);
            offset    = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 15)) - 8);
            target    = 9'($urandom);
            mem_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_addr_unit.md
PC_ADDR_UNIT -- requirements
Module: pc_addr_unit

Interface
REQ-001 Parameter: ADDR_W, default 9, memory address width in bits.
REQ-002 Parameter: DATA_W, default 16, width of offset operand.
REQ-003 Parameter: RESET_VEC, default 0, PC value after reset and for pc_mode 11.
REQ-004 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: fetch_req  in  1  request instruction read at current PC.
REQ-007 Port: data_req  in  1  request data access at data address register.
REQ-008 Port: data_we  in  1  data access is a write (sampled with data_req).
REQ-009 Port: load_addr  in  1  latch addr_in into data address register.
REQ-010 Port: addr_in  in  ADDR_W  data address source (datapath result, low bits).
REQ-011 Port: load_pc  in  1  update PC per pc_mode.
REQ-012 Port: pc_mode  in  2  00 PC+1; 01 PC+1+offset; 10 target; 11 RESET_VEC.
REQ-013 Port: offset  in  DATA_W  sign-extended branch displacement.
REQ-014 Port: target  in  ADDR_W  absolute branch target.
REQ-015 Port: mem_ready  in  1  memory completes current access this cycle.
REQ-016 Port: mem_addr  out  ADDR_W  address to memory.
REQ-017 Port: mem_cmd  out  2  00 none, 01 read, 10 write.
REQ-018 Port: busy  out  1  access in progress.
REQ-019 Port: done  out  1  one-cycle pulse, access completed.
REQ-020 Port: done_fetch  out  1  qualifies done: 1 = fetch, 0 = data.
REQ-021 Port: pc  out  ADDR_W  current PC.

Function
REQ-022 FSM states SHALL be IDLE, FETCH, DATA_RD, DATA_WR.
REQ-023 IDLE: fetch_req -> FETCH; else data_req -> DATA_WR if data_we, else DATA_RD; fetch_req wins when both asserted.
REQ-024 FETCH/DATA_*: remain until mem_ready=1, then return to IDLE next edge; requests arriving while busy SHALL be ignored (not queued).
REQ-025 mem_cmd SHALL be 01 in FETCH and DATA_RD, 10 in DATA_WR, 00 in IDLE; combinational from state.
REQ-026 mem_addr SHALL be pc in FETCH, data address register in DATA_*, pc in IDLE.
REQ-027 busy SHALL be 1 in every non-IDLE state.
REQ-028 done SHALL pulse for exactly one cycle, registered, in the cycle after mem_ready was sampled in a non-IDLE state; done_fetch valid in that cycle.
REQ-029 PC arithmetic SHALL be modulo 2^ADDR_W; offset truncated to ADDR_W after sign extension; wrap from all-ones to 0 is legal.
REQ-030 load_pc SHALL be ignored while in FETCH (PC stable during fetch); accepted in all other states.
REQ-031 load_addr SHALL be ignored while in DATA_RD/DATA_WR; accepted otherwise.
REQ-032 mem_ready sampled in IDLE SHALL have no effect.

Reset
REQ-033 reset=1 at a rising edge SHALL force state IDLE, pc=RESET_VEC, data address register=0, done=0, done_fetch=0, regardless of other inputs.
REQ-034 reset asserted mid-access SHALL abort it: no done pulse, mem_cmd=00 the cycle after.
REQ-035 Reset SHALL take priority over load_pc, load_addr and requests in the same cycle.

Structure
REQ-036 Shared package SHALL hold the state enum, mem_cmd encoding constants and pc_mode encoding constants.
REQ-037 One sub-module, pc_next, SHALL compute the next-PC value combinationally from pc, pc_mode, offset, target.
REQ-038 PC and data address registers SHALL be load-enabled registers, no latches.

Verification
REQ-039 Reset, then fetch_req with mem_ready after 2 wait cycles -> mem_cmd=01, mem_addr=0 for 3 cycles, done=1 and done_fetch=1 one cycle later.
REQ-040 load_addr with addr_in=0x1A5, then data_req, data_we=1, mem_ready immediate -> mem_cmd=10, mem_addr=0x1A5, done=1, done_fetch=0.
REQ-041 pc=0x1FF, load_pc, pc_mode=00 -> pc=0x000; pc=0x005, pc_mode=01, offset=0xFFFD -> pc=0x003.
REQ-042 fetch_req and data_req together in IDLE -> FETCH taken; data_req later raised while busy -> no data access follows.
REQ-043 reset asserted during DATA_RD before mem_ready -> IDLE, pc=RESET_VEC, no done pulse.
REQ-044 load_pc pc_mode=10 target=0x0C0 during FETCH -> pc unchanged; same in IDLE -> pc=0x0C0.
